// File: rtl/maze_mem_arbiter.sv
// Single-port maze map RAM arbiter for the host loader (R0), solver (R1) and
// display scanner (R2): registered grants, solver lock, display starvation guard.
module maze_mem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 1,
  parameter int STARVE_MAX = 8,
  parameter int LOCK_MAX   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              req2,
  input  logic              we0,
  input  logic              we1,
  input  logic              we2,
  input  logic              lock0,
  input  logic              lock1,
  input  logic              lock2,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] wdata2,
  output logic              gnt0,
  output logic              gnt1,
  output logic              gnt2,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic              rvalid2,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lock_err
);

  localparam int WW = $clog2(STARVE_MAX + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, OWN2} state_t;

  state_t              state, state_n, own_state;
  logic                rr_ptr, rr_n;        // 0: R1 favoured, 1: R2 favoured
  logic [WW-1:0]       wait2, wait2_n;
  logic [LW-1:0]       lock_cnt, lock_cnt_n;
  logic [2:0]          req, lk, wsel;
  logic                lerr_n;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_we, sel_lock;

  assign req   = {req2, req1, req0};
  assign lk    = {lock2, lock1, lock0};
  assign rdata = mem_rdata;

  always_comb begin
    sel_addr  = ({ADDR_W{wsel[0]}} & addr0) | ({ADDR_W{wsel[1]}} & addr1)
              | ({ADDR_W{wsel[2]}} & addr2);
    sel_wdata = ({DATA_W{wsel[0]}} & wdata0) | ({DATA_W{wsel[1]}} & wdata1)
              | ({DATA_W{wsel[2]}} & wdata2);
    sel_we    = |(wsel & {we2, we1, we0});
    sel_lock  = |(wsel & lk);
    own_state = wsel[0] ? OWN0 : (wsel[1] ? OWN1 : OWN2);
  end

  always_comb begin
    wsel       = '0;
    state_n    = state;
    lock_cnt_n = lock_cnt;
    lerr_n     = 1'b0;
    rr_n       = rr_ptr;
    wait2_n    = wait2;

    unique case (state)
      IDLE: begin
        if (req[2] && wait2 == WW'(STARVE_MAX)) wsel = 3'b100;
        else if (req[0])                        wsel = 3'b001;
        else if (req[1] && (!req[2] || !rr_ptr)) wsel = 3'b010;
        else if (req[2])                        wsel = 3'b100;
      end
      OWN0: if (req[0]) wsel = 3'b001; else begin state_n = IDLE; lock_cnt_n = '0; end
      OWN1: if (req[1]) wsel = 3'b010; else begin state_n = IDLE; lock_cnt_n = '0; end
      OWN2: if (req[2]) wsel = 3'b100; else begin state_n = IDLE; lock_cnt_n = '0; end
      default: state_n = IDLE;
    endcase

    if (|wsel) begin
      if (state == IDLE) begin
        if (sel_lock) begin
          state_n    = own_state;
          lock_cnt_n = LW'(1);
        end
      end else if (sel_lock && lock_cnt == LW'(LOCK_MAX)) begin
        // The over-limit access still goes out; only ownership is revoked.
        lerr_n     = 1'b1;
        state_n    = IDLE;
        lock_cnt_n = '0;
      end else if (sel_lock) begin
        lock_cnt_n = lock_cnt + LW'(1);
      end else begin
        state_n    = IDLE;
        lock_cnt_n = '0;
      end
    end

    if (wsel[1] || wsel[2]) rr_n = wsel[1];

    if (!req[2] || wsel[2])               wait2_n = '0;
    else if (wait2 != WW'(STARVE_MAX))    wait2_n = wait2 + WW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      wait2    <= '0;
      lock_cnt <= '0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_n;
      wait2    <= wait2_n;
      lock_cnt <= lock_cnt_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {gnt2, gnt1, gnt0}          <= '0;
      {rvalid2, rvalid1, rvalid0} <= '0;
      mem_we                      <= 1'b0;
      mem_addr                    <= '0;
      mem_wdata                   <= '0;
      lock_err                    <= 1'b0;
    end else begin
      {gnt2, gnt1, gnt0}          <= wsel;
      {rvalid2, rvalid1, rvalid0} <= {gnt2, gnt1, gnt0} & {3{~mem_we}};
      mem_we                      <= (|wsel) & sel_we;
      lock_err                    <= lerr_n;
      if (|wsel) begin
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
      end
    end
  end

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Bench for maze_mem_arbiter: directed requester scenarios, a behavioural
// arbitration model checked every cycle, and hand-computed literal checks.
module tb_maze_mem_arbiter;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 1;
  localparam int STARVE = 8;
  localparam int LOCKMX = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req0 = 0, req1 = 0, req2 = 0;
  logic              we0 = 0, we1 = 0, we2 = 0;
  logic              lock0 = 0, lock1 = 0, lock2 = 0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0, addr2 = '0;
  logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0, wdata2 = '0;
  logic              gnt0, gnt1, gnt2, rvalid0, rvalid1, rvalid2;
  logic [DATA_W-1:0] rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we, lock_err;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  maze_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE), .LOCK_MAX(LOCKMX)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .req2(req2),
    .we0(we0), .we1(we1), .we2(we2),
    .lock0(lock0), .lock1(lock1), .lock2(lock2),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .gnt0(gnt0), .gnt1(gnt1), .gnt2(gnt2),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rvalid2(rvalid2),
    .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .lock_err(lock_err)
  );

  always #5 clk = ~clk;

  // Write-first synchronous RAM with one cycle of read latency
  logic [DATA_W-1:0] ram [256];
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;
    ram[8'h35] = 1'b1;
    mem_rdata = '0;
  end
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] = mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: owner -1 means nobody holds the lock; rr is the favoured of R1/R2
  int         owner, w2, lcnt, rr;
  logic [2:0] e_gnt, e_rv;
  logic       e_we, e_lerr;
  logic [7:0] e_addr;
  logic       e_wd, e_rd, e_rd_next;
  bit         mref [256];

  initial begin
    for (int i = 0; i < 256; i++) mref[i] = 0;
    mref[8'h35] = 1;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      owner = -1; w2 = 0; lcnt = 0; rr = 1;
      e_gnt = 0; e_rv = 0; e_we = 0; e_lerr = 0; e_addr = 0; e_wd = 0;
      e_rd = 0; e_rd_next = 0;
    end else begin
      int w;
      logic [2:0] r, l, wv;
      r  = {req2, req1, req0};
      l  = {lock2, lock1, lock0};
      wv = {we2, we1, we0};
      e_rv = e_we ? 3'b000 : e_gnt;
      e_rd = e_rd_next;
      w = -1;
      if (owner >= 0) begin
        if (r[owner]) w = owner;
        else begin owner = -1; lcnt = 0; end
      end else if (r[2] && w2 == STARVE) w = 2;
      else if (r[0]) w = 0;
      else if (r[1] && r[2]) w = rr;
      else if (r[1]) w = 1;
      else if (r[2]) w = 2;
      if (!r[2] || w == 2) w2 = 0;
      else if (w2 < STARVE) w2++;
      e_gnt = 0; e_we = 0; e_lerr = 0;
      if (w >= 0) begin
        e_gnt[w] = 1'b1;
        e_we     = wv[w];
        e_addr   = (w == 0) ? addr0 : (w == 1) ? addr1 : addr2;
        e_wd     = (w == 0) ? wdata0 : (w == 1) ? wdata1 : wdata2;
        if (e_we) mref[e_addr] = e_wd;
        else e_rd_next = mref[e_addr];
        if (w != 0) rr = (w == 1) ? 2 : 1;
        if (owner < 0) begin
          if (l[w]) begin owner = w; lcnt = 1; end
        end else if (l[w] && lcnt == LOCKMX) begin
          e_lerr = 1; owner = -1; lcnt = 0;
        end else if (l[w]) lcnt++;
        else begin owner = -1; lcnt = 0; end
      end
    end
  end

  always @(negedge clk) begin
    if (started && !rst) begin
      check("model_gnt", {29'd0, gnt2, gnt1, gnt0}, {29'd0, e_gnt});
      check("model_rvalid", {29'd0, rvalid2, rvalid1, rvalid0}, {29'd0, e_rv});
      check("model_mem_we", {31'd0, mem_we}, {31'd0, e_we});
      check("model_mem_addr", {24'd0, mem_addr}, {24'd0, e_addr});
      check("model_mem_wdata", {31'd0, mem_wdata}, {31'd0, e_wd});
      check("model_lock_err", {31'd0, lock_err}, {31'd0, e_lerr});
      if (|e_rv) check("model_rdata", {31'd0, rdata}, {31'd0, e_rd});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    {req0, req1, req2}    = '0;
    {we0, we1, we2}       = '0;
    {lock0, lock1, lock2} = '0;
    addr0 = '0; addr1 = '0; addr2 = '0;
    wdata0 = '0; wdata1 = '0; wdata2 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] gv();
    return {29'd0, gnt2, gnt1, gnt0};
  endfunction

  initial begin
    #2;
    idle_inputs();
    rst = 1'b1;
    started = 1;
    tick();
    check("rst_gnt", gv(), 32'd0);
    check("rst_rvalid", {29'd0, rvalid2, rvalid1, rvalid0}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", {31'd0, mem_wdata}, 32'd0);
    check("rst_lock_err", {31'd0, lock_err}, 32'd0);
    rst = 1'b0;

    // Single read of 0x35 by R1
    req1 = 1; we1 = 0; addr1 = 8'h35;
    tick();
    check("rd_gnt", gv(), 32'b010);
    check("rd_addr", {24'd0, mem_addr}, 32'h35);
    check("rd_we", {31'd0, mem_we}, 32'd0);
    req1 = 0;
    tick();
    check("rd_rvalid", {29'd0, rvalid2, rvalid1, rvalid0}, 32'b010);
    check("rd_rdata", {31'd0, rdata}, 32'd1);
    check("rd_no_gnt", gv(), 32'd0);
    tick();

    // All three request at reset exit
    idle_inputs();
    rst = 1'b1;
    req0 = 1; addr0 = 8'h01;
    req1 = 1; addr1 = 8'h02;
    req2 = 1; addr2 = 8'h03;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("prio_1st", gv(), 32'b001);
    req0 = 0;
    tick();
    check("prio_2nd", gv(), 32'b010);
    req1 = 0;
    tick();
    check("prio_3rd", gv(), 32'b100);
    req2 = 0;
    tick();
    tick();

    // Locked read-modify-write by R1 while R0 waits
    do_reset();
    req1 = 1; lock1 = 1; we1 = 0; addr1 = 8'h12;
    tick();
    check("rmw_rd_gnt", gv(), 32'b010);
    check("rmw_rd_we", {31'd0, mem_we}, 32'd0);
    we1 = 1; wdata1 = 1; lock1 = 0;
    req0 = 1; we0 = 0; addr0 = 8'h12;
    tick();
    check("rmw_wr_gnt", gv(), 32'b010);
    check("rmw_wr_we", {31'd0, mem_we}, 32'd1);
    req1 = 0;
    tick();
    check("rmw_r0_gnt", gv(), 32'b001);
    req0 = 0;
    tick();
    check("rmw_r0_rvalid", {31'd0, rvalid0}, 32'd1);
    check("rmw_r0_rdata", {31'd0, rdata}, 32'd1);
    tick();

    // Lock timeout with R2 waiting
    do_reset();
    req1 = 1; lock1 = 1; addr1 = 8'h21;
    req2 = 1; addr2 = 8'h22;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("lto_gnt%0d", i), gv(), 32'b010);
      check($sformatf("lto_err%0d", i), {31'd0, lock_err}, (i == 5) ? 32'd1 : 32'd0);
    end
    tick();
    check("lto_r2_gnt", gv(), 32'b100);
    idle_inputs();
    tick();
    tick();

    // Display starvation against a continuous host stream
    do_reset();
    req0 = 1; addr0 = 8'h40;
    req2 = 1; addr2 = 8'h41;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("stv_r0_%0d", i), gv(), 32'b001);
    end
    tick();
    check("stv_r2", gv(), 32'b100);
    req2 = 0;
    tick();
    check("stv_r0_resume", gv(), 32'b001);
    idle_inputs();
    tick();
    tick();

    // Reset during an R2 read
    do_reset();
    req2 = 1; we2 = 0; addr2 = 8'h35;
    tick();
    check("mid_gnt2", gv(), 32'b100);
    req2 = 0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #4;
      check("mid_rvalid2", {31'd0, rvalid2}, 32'd0);
      check("mid_mem_we", {31'd0, mem_we}, 32'd0);
      tick();
    end
    rst = 1'b0;
    tick();
    check("mid_rvalid2_after", {31'd0, rvalid2}, 32'd0);
    check("mid_idle_gnt", gv(), 32'd0);
    req1 = 1; addr1 = 8'h35;
    tick();
    check("mid_post_gnt1", gv(), 32'b010);
    req1 = 0;
    tick();
    check("mid_post_rvalid1", {31'd0, rvalid1}, 32'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
